// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (a - b - bin) one bit per clock, LSB first,
// and publishes diff/bout/ovf together once all WIDTH bits are done.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic             w_d, w_bnext, w_last, w_accept;
  logic [WIDTH-1:0] w_res_next;

  // One full-subtractor slice on the current operand LSBs.
  assign w_d        = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_bnext    = (~r_a[0] & (r_b[0] | r_borrow)) | (r_b[0] & r_borrow);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_accept   = (r_state == S_IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and status outputs; DONE always falls back to IDLE.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand shift registers, borrow chain, bit counter and result registers.
  // On the last shift edge r_a[0]/r_b[0] hold the original sign bits and w_d
  // is the result sign, so overflow is resolved without extra sign storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_res    <= '0;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_res    <= w_res_next;
      r_borrow <= w_bnext;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        diff <= w_res_next;
        bout <= w_bnext;
        ovf  <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): the driver queues the
// expected result at each acceptance; a negedge monitor pops on done.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           acc;
  } exp_t;

  logic         clk, rst_n, start, bin;
  logic [W-1:0] a, b, diff;
  logic         bout, ovf, busy, done;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q[$];
  exp_t last;
  int   prev_done;
  logic burst;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .bout(bout), .ovf(ovf), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model written straight from the arithmetic definition.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    logic [W:0] full;
    full  = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.d   = full[W-1:0];
    e.bo  = (int'(x) < int'(y) + int'(bi));
    e.ov  = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: results at done, latency, burst period, and hold between ops.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("diff", int'(diff), int'(e.d));
          chk("bout", int'(bout), int'(e.bo));
          chk("ovf", int'(ovf), int'(e.ov));
          chk("latency", cyc - e.acc, W);
          if (burst && prev_done >= 0) chk("done_period", cyc - prev_done, W + 2);
          prev_done = cyc;
          last = e;
        end
      end else begin
        chk("hold", int'({diff, bout, ovf}), int'({last.d, last.bo, last.ov}));
      end
    end
  end

  // Wait for IDLE, raise start for one edge and queue the expectation.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                       input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("idle_timeout", 1, 0);
    end else begin
      a = x; b = y; bin = bi; start = 1'b1;
      e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  function automatic exp_t mk(input int d, input int bo, input int ov);
    exp_t e;
    e.d = d[W-1:0]; e.bo = bo[0]; e.ov = ov[0]; e.acc = 0;
    return e;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int lows, accs;
    last = '0; prev_done = -1; burst = 1'b0;
    start = 0; a = 0; b = 0; bin = 0; rst_n = 0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'({diff, bout, ovf}), 0);
    @(negedge clk) rst_n = 1;

    // Directed vectors, hand-computed expectations.
    issue(4'd9, 4'd3, 1'b0, mk(6, 0, 1));
    issue(4'd3, 4'd5, 1'b0, mk(14, 1, 0));
    issue(4'd0, 4'd0, 1'b1, mk(15, 1, 0));
    issue(4'd6, 4'd6, 1'b0, mk(0, 0, 0));
    issue(4'd7, 4'd8, 1'b0, mk(15, 1, 1));
    // Disturb inputs and pulse start while the 7-8 op is shifting.
    @(negedge clk); chk("busy_in_shift", int'(busy), 1);
    a = 4'd1; b = 4'd1; bin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    drain();

    // Reset two edges after acceptance aborts with no done pulse.
    issue(4'd12, 4'd1, 1'b0, mk(11, 0, 0));
    @(posedge clk); @(posedge clk); #2;
    rst_n = 0; #1;
    q.delete(); last = '0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_diff", int'(diff), 0);
    chk("abort_flags", int'({bout, ovf, done}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    issue(4'd5, 4'd5, 1'b0, mk(0, 0, 0));
    drain();

    // start held high for 20 cycles: accepts every W+2 cycles.
    burst = 1'b1; prev_done = -1; lows = 0; accs = 0;
    a = 4'd2; b = 4'd9; bin = 1'b1;
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (!busy) begin
        exp_t e;
        e = mk(8, 1, 1);
        e.acc = cyc + 1;
        q.push_back(e);
        lows++; accs++;
      end
    end
    start = 1'b0;
    chk("burst_idle_cycles", lows, 4);
    chk("burst_accepts", accs, 4);
    drain();
    burst = 1'b0;

    // Exhaustive sweep against the model.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      issue(v[8:5], v[4:1], v[0], model(v[8:5], v[4:1], v[0]));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
